// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response path.
package puf_pkg;
  localparam logic [7:0] RESPONSE_ID = 8'hAB;
  localparam logic [7:0] REQUEST_ID  = 8'hA5;

  typedef enum logic [3:0] {
    PKT_IDLE, PKT_HDR, PKT_CNT_LO, PKT_CNT_HI, PKT_FETCH,
    PKT_WAIT_RD, PKT_PAYLOAD, PKT_CSUM, PKT_DONE
  } pkt_state_t;

  typedef enum logic [2:0] {
    SND_IDLE, SND_WAIT_FREE, SND_PULSE, SND_WAIT_HI, SND_WAIT_LO
  } snd_state_t;

  function automatic int bytes_per_word(input int bits, input int byte_bits = 8);
    return (bits + byte_bits - 1) / byte_bits;
  endfunction
endpackage

// File: rtl/uart_byte_sender.sv
// One-byte UART handshake: waits for idle line, pulses tx_enable, tracks tx_busy rise then fall.
module uart_byte_sender
  import puf_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] byte_in,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_enable,
  input  logic                 tx_busy,
  output logic                 sent
);
  snd_state_t state, state_nxt;
  logic       load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SND_IDLE;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      if (load) tx_data <= byte_in;
    end
  end

  // tx_busy is only checked for its rise after the pulse cycle, so a
  // UART with one cycle of latency is never mistaken for "already done".
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tx_enable = 1'b0;
    sent      = 1'b0;
    case (state)
      SND_IDLE: if (send) begin
        load      = 1'b1;
        state_nxt = tx_busy ? SND_WAIT_FREE : SND_PULSE;
      end
      SND_WAIT_FREE: if (!tx_busy) state_nxt = SND_PULSE;
      SND_PULSE: begin
        tx_enable = 1'b1;
        state_nxt = SND_WAIT_HI;
      end
      SND_WAIT_HI: if (tx_busy) state_nxt = SND_WAIT_LO;
      SND_WAIT_LO: if (!tx_busy) begin
        sent      = 1'b1;
        state_nxt = SND_IDLE;
      end
      default: state_nxt = SND_IDLE;
    endcase
  end
endmodule

// File: rtl/response_packetizer.sv
// Drains NUM_WORDS FIFO words and frames them as ID, count LSB/MSB, payload LSB-first, checksum.
module response_packetizer #(
  parameter int         RESPONSE_BITS = 32,
  parameter int         DATA_BITS     = 8,
  parameter int         NUM_WORDS     = 1280,
  parameter logic [7:0] RESPONSE_ID   = puf_pkg::RESPONSE_ID,
  parameter int         STALL_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic [RESPONSE_BITS-1:0] fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic [DATA_BITS-1:0]     tx_data,
  output logic                     tx_enable,
  input  logic                     tx_busy
);
  import puf_pkg::*;

  localparam int          BPW    = bytes_per_word(RESPONSE_BITS, DATA_BITS);
  localparam int          SH_W   = BPW * DATA_BITS;
  localparam int          WC_W   = $clog2(NUM_WORDS + 1);
  localparam int          ST_W   = $clog2(STALL_TIMEOUT + 1);
  localparam int          BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [15:0] NW16   = 16'(NUM_WORDS);

  pkt_state_t            state, state_nxt;
  logic [WC_W-1:0]       word_cnt;
  logic [BIDX_W-1:0]     byte_idx;
  logic [ST_W-1:0]       stall_cnt;
  logic [DATA_BITS-1:0]  csum;
  logic [SH_W-1:0]       shreg;
  logic                  issued;
  logic                  send, sent;
  logic [DATA_BITS-1:0]  send_byte;
  logic                  is_tx, sum_byte, accept, abort, stall_inc;
  logic                  latch_word, byte_adv, last_byte;

  assign last_byte = (byte_idx == BIDX_W'(BPW - 1));
  assign send      = is_tx && !issued;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PKT_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    fifo_rd_en = 1'b0;
    send_byte  = '0;
    is_tx      = 1'b0;
    sum_byte   = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    stall_inc  = 1'b0;
    latch_word = 1'b0;
    byte_adv   = 1'b0;
    case (state)
      PKT_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = PKT_HDR;
        end
      end
      PKT_HDR: begin
        is_tx     = 1'b1;
        send_byte = DATA_BITS'(RESPONSE_ID);
        if (sent) state_nxt = PKT_CNT_LO;
      end
      PKT_CNT_LO: begin
        is_tx     = 1'b1;
        sum_byte  = 1'b1;
        send_byte = DATA_BITS'(NW16[7:0]);
        if (sent) state_nxt = PKT_CNT_HI;
      end
      PKT_CNT_HI: begin
        is_tx     = 1'b1;
        sum_byte  = 1'b1;
        send_byte = DATA_BITS'(NW16[15:8]);
        if (sent) state_nxt = PKT_FETCH;
      end
      PKT_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = PKT_WAIT_RD;
        end else if (stall_cnt == ST_W'(STALL_TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = PKT_IDLE;
        end else begin
          stall_inc = 1'b1;
        end
      end
      PKT_WAIT_RD: begin
        latch_word = 1'b1;
        state_nxt  = PKT_PAYLOAD;
      end
      PKT_PAYLOAD: begin
        is_tx     = 1'b1;
        sum_byte  = 1'b1;
        send_byte = shreg[DATA_BITS-1:0];
        if (sent) begin
          byte_adv = 1'b1;
          if (last_byte)
            state_nxt = (word_cnt == WC_W'(NUM_WORDS - 1)) ? PKT_CSUM : PKT_FETCH;
        end
      end
      PKT_CSUM: begin
        is_tx     = 1'b1;
        send_byte = csum;
        if (sent) state_nxt = PKT_DONE;
      end
      PKT_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = PKT_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = PKT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error     <= 1'b0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      stall_cnt <= '0;
      csum      <= '0;
      shreg     <= '0;
      issued    <= 1'b0;
    end else begin
      if (accept) begin
        error     <= 1'b0;
        word_cnt  <= '0;
        byte_idx  <= '0;
        stall_cnt <= '0;
        csum      <= '0;
      end
      if (abort) error <= 1'b1;
      if (sent)      issued <= 1'b0;
      else if (send) issued <= 1'b1;
      if (sent && sum_byte) csum <= csum + send_byte;
      if (fifo_rd_en)     stall_cnt <= '0;
      else if (stall_inc) stall_cnt <= stall_cnt + ST_W'(1);
      // Zero-extension pads the unused top bits of the last byte.
      if (latch_word) shreg <= SH_W'(fifo_dout);
      if (byte_adv) begin
        shreg    <= shreg >> DATA_BITS;
        byte_idx <= last_byte ? '0 : byte_idx + BIDX_W'(1);
        if (last_byte) word_cnt <= word_cnt + WC_W'(1);
      end
    end
  end

  uart_byte_sender #(.DATA_BITS(DATA_BITS)) u_sender (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .byte_in   (send_byte),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .tx_busy   (tx_busy),
    .sent      (sent)
  );
endmodule
